// File: rtl/detect_faces_mul_arbiter_pkg.sv
// Shared sizing constants and the round-robin pick helper for the
// multiplier arbiter.
package detect_faces_mul_arbiter_pkg;

    localparam int unsigned NumReq    = 4;
    localparam int unsigned DataW     = 32;
    localparam int unsigned IdW       = 2;
    localparam int unsigned OpCntW    = 32;
    localparam int unsigned StallCntW = 16;

    // First eligible index after `last`, wrapping; returns `last` when none is eligible.
    function automatic logic [IdW-1:0] rr_pick(input logic [NumReq-1:0] elig,
                                               input logic [IdW-1:0]    last);
        logic [IdW-1:0] pick;
        logic [IdW-1:0] idx;
        pick = last;
        for (int k = NumReq; k >= 1; k--) begin
            idx = last + IdW'(k);
            if (elig[idx]) begin
                pick = idx;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/detect_faces_mul_u32_stage.sv
// Registered unsigned multiplier, one cycle latency, advancing only on ce.
// The product register is deliberately unreset; the owner qualifies it with a valid.
module detect_faces_mul_u32_stage
    import detect_faces_mul_arbiter_pkg::*;
#(
    parameter int unsigned Width = DataW
) (
    input  logic               clk_i,
    input  logic               ce_i,
    input  logic [Width-1:0]   a_i,
    input  logic [Width-1:0]   b_i,
    output logic [2*Width-1:0] p_o
);

    logic [2*Width-1:0] p_d;
    logic [2*Width-1:0] p_q;

    always_comb begin
        p_d = {{Width{1'b0}}, a_i} * {{Width{1'b0}}, b_i};
    end

    always_ff @(posedge clk_i) begin
        if (ce_i) begin
            p_q <= p_d;
        end
    end

    assign p_o = p_q;

endmodule

// File: rtl/detect_faces_mul_arbiter.sv
// Round-robin arbiter sharing one registered 32x32 multiplier among four requesters,
// with a one-deep result register, backpressure via res_ready, and activity counters.
module detect_faces_mul_arbiter
    import detect_faces_mul_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = NumReq,
    parameter int unsigned DATA_W  = DataW
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      enable,
    input  logic [NUM_REQ-1:0]        req_mask,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_a,
    input  logic [NUM_REQ*DATA_W-1:0] req_b,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic [IdW-1:0]            res_id,
    output logic [2*DATA_W-1:0]       res_data,
    output logic [OpCntW-1:0]         op_cnt,
    output logic [StallCntW-1:0]      stall_cnt
);

    logic [NUM_REQ-1:0]   eligible;
    logic                 ce;
    logic                 grant;
    logic [IdW-1:0]       grant_idx;
    logic [DATA_W-1:0]    mul_a;
    logic [DATA_W-1:0]    mul_b;
    logic [2*DATA_W-1:0]  mul_p;

    logic                 res_valid_d, res_valid_q;
    logic [IdW-1:0]       res_id_d, res_id_q;
    logic [IdW-1:0]       last_grant_d, last_grant_q;
    logic [OpCntW-1:0]    op_cnt_d, op_cnt_q;
    logic [StallCntW-1:0] stall_cnt_d, stall_cnt_q;

    // Gating grant with reset_n keeps req_ready low throughout reset.
    always_comb begin
        eligible  = req_valid & req_mask;
        ce        = !res_valid_q || res_ready;
        grant     = reset_n && enable && ce && (|eligible);
        grant_idx = rr_pick(eligible, last_grant_q);
        req_ready = grant ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << grant_idx) : '0;
        mul_a     = req_a[32'(grant_idx) * DATA_W +: DATA_W];
        mul_b     = req_b[32'(grant_idx) * DATA_W +: DATA_W];
    end

    detect_faces_mul_u32_stage #(
        .Width (DATA_W)
    ) u_mul (
        .clk_i (clk),
        .ce_i  (ce),
        .a_i   (mul_a),
        .b_i   (mul_b),
        .p_o   (mul_p)
    );

    always_comb begin
        res_valid_d  = res_valid_q;
        res_id_d     = res_id_q;
        last_grant_d = last_grant_q;
        op_cnt_d     = op_cnt_q;
        stall_cnt_d  = stall_cnt_q;
        if (ce) begin
            res_valid_d = grant;
            if (grant) begin
                res_id_d = grant_idx;
            end
        end
        if (grant) begin
            last_grant_d = grant_idx;
            op_cnt_d     = op_cnt_q + OpCntW'(1);
        end
        if (res_valid_q && !res_ready && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + StallCntW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            res_valid_q  <= 1'b0;
            res_id_q     <= '0;
            last_grant_q <= IdW'(NUM_REQ - 1);
            op_cnt_q     <= '0;
            stall_cnt_q  <= '0;
        end else begin
            res_valid_q  <= res_valid_d;
            res_id_q     <= res_id_d;
            last_grant_q <= last_grant_d;
            op_cnt_q     <= op_cnt_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    // The product register has no reset, so data is forced to zero whenever invalid.
    assign res_valid = res_valid_q;
    assign res_id    = res_id_q;
    assign res_data  = res_valid_q ? mul_p : '0;
    assign op_cnt    = op_cnt_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_detect_faces_mul_arbiter.sv
// Scoreboard bench: the driver predicts grants and products, a negedge monitor checks results.
module tb_detect_faces_mul_arbiter;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         enable = 1'b0;
    logic [3:0]   req_mask = 4'h0;
    logic [3:0]   req_valid = 4'h0;
    logic [3:0]   req_ready;
    logic [127:0] req_a = '0;
    logic [127:0] req_b = '0;
    logic         res_valid;
    logic         res_ready = 1'b0;
    logic [1:0]   res_id;
    logic [63:0]  res_data;
    logic [31:0]  op_cnt;
    logic [15:0]  stall_cnt;

    detect_faces_mul_arbiter dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .enable    (enable),
        .req_mask  (req_mask),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_id    (res_id),
        .res_data  (res_data),
        .op_cnt    (op_cnt),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned cyc;
        logic [1:0]  id;
        logic [63:0] data;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;
    logic        mon_en = 1'b0;
    logic        due;

    // Reference model state
    logic        m_valid = 1'b0;
    int          m_ptr = 3;
    logic [31:0] m_op = 0;
    int          m_stall = 0;
    logic [31:0] op_a[4];
    logic [31:0] op_b[4];

    task automatic chk(input string name, input logic ok, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(input logic [3:0] v, input logic [3:0] m, input logic en,
                        input logic rdy, input logic rst);
        logic [3:0] elig;
        logic [3:0] exp_rdy;
        logic       ce_m;
        logic       g;
        logic       was_valid;
        int         win;
        reset_n   = rst;
        enable    = en;
        req_valid = v;
        req_mask  = m;
        res_ready = rdy;
        for (int i = 0; i < 4; i++) begin
            req_a[i*32 +: 32] = op_a[i];
            req_b[i*32 +: 32] = op_b[i];
        end
        #1;
        elig = v & m;
        ce_m = !m_valid || rdy;
        g    = rst && en && ce_m && (elig != 4'h0);
        win  = -1;
        for (int k = 1; k <= 4; k++) begin
            if (win < 0 && elig[(m_ptr + k) % 4]) win = (m_ptr + k) % 4;
        end
        exp_rdy = g ? (4'h1 << win) : 4'h0;
        chk("req_ready", req_ready === exp_rdy, 64'(req_ready), 64'(exp_rdy));
        if (g) sb.push_back('{cyc, 2'(win), 64'(op_a[win]) * 64'(op_b[win])});
        was_valid = m_valid;
        @(posedge clk);
        #1;
        cyc++;
        if (!rst) begin
            sb.delete();
            m_valid = 1'b0;
            m_ptr   = 3;
            m_op    = 0;
            m_stall = 0;
        end else begin
            if (ce_m) m_valid = g;
            if (g) begin
                m_ptr = win;
                m_op  = m_op + 1;
            end
            if (was_valid && !rdy && m_stall < 65535) m_stall++;
        end
        chk("op_cnt", op_cnt === m_op, 64'(op_cnt), 64'(m_op));
        chk("stall_cnt", stall_cnt === 16'(m_stall), 64'(stall_cnt), 64'(m_stall));
    endtask

    // A result pushed in an earlier cycle must be on res_*; pop it when consumed.
    always @(negedge clk) begin
        if (mon_en) begin
            due = 1'b0;
            if (sb.size() > 0) begin
                if (sb[0].cyc < cyc) due = 1'b1;
            end
            chk("res_valid", res_valid === due, 64'(res_valid), 64'(due));
            if (due && res_valid) begin
                chk("res_id", res_id === sb[0].id, 64'(res_id), 64'(sb[0].id));
                chk("res_data", res_data === sb[0].data, res_data, sb[0].data);
                if (res_ready) void'(sb.pop_front());
            end
        end
    end

    initial begin
        for (int i = 0; i < 4; i++) begin
            op_a[i] = 32'(i + 1);
            op_b[i] = 32'(i + 3);
        end
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        chk("reset res_data", res_data === 64'h0, res_data, 64'h0);
        step(4'hF, 4'hF, 1'b1, 1'b1, 1'b0);
        step(4'hF, 4'hF, 1'b1, 1'b1, 1'b0);

        // Single request from requester 2: 7*6
        op_a[2] = 32'd7;
        op_b[2] = 32'd6;
        step(4'b0100, 4'hF, 1'b1, 1'b1, 1'b1);
        step(4'b0000, 4'hF, 1'b1, 1'b1, 1'b1);

        // All requesters busy: rotating grants
        for (int n = 0; n < 8; n++) begin
            for (int i = 0; i < 4; i++) begin
                op_a[i] = $urandom;
                op_b[i] = $urandom;
            end
            step(4'hF, 4'hF, 1'b1, 1'b1, 1'b1);
        end

        // Largest operands
        op_a[0] = 32'hFFFF_FFFF;
        op_b[0] = 32'hFFFF_FFFF;
        step(4'b0001, 4'hF, 1'b1, 1'b1, 1'b1);

        // Backpressure for 5 cycles, then release
        step(4'hF, 4'hF, 1'b1, 1'b1, 1'b1);
        for (int n = 0; n < 5; n++) step(4'hF, 4'hF, 1'b1, 1'b0, 1'b1);
        for (int n = 0; n < 4; n++) step(4'hF, 4'hF, 1'b1, 1'b1, 1'b1);

        // Mask leaves only 1 and 3; then enable low drains the pending result
        for (int n = 0; n < 4; n++) step(4'hF, 4'b1010, 1'b1, 1'b1, 1'b1);
        for (int n = 0; n < 3; n++) step(4'hF, 4'hF, 1'b0, 1'b1, 1'b1);

        // Reset while a result is held
        step(4'hF, 4'hF, 1'b1, 1'b1, 1'b1);
        step(4'hF, 4'hF, 1'b1, 1'b0, 1'b1);
        step(4'hF, 4'hF, 1'b1, 1'b0, 1'b0);
        for (int n = 0; n < 3; n++) step(4'hF, 4'hF, 1'b1, 1'b1, 1'b1);

        // Randomised traffic
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < 4; i++) begin
                op_a[i] = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
                op_b[i] = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
            end
            step(4'($urandom),
                 ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF,
                 $urandom_range(0, 9) != 0,
                 $urandom_range(0, 9) < 7,
                 $urandom_range(0, 149) != 0);
        end

        for (int n = 0; n < 3; n++) step(4'h0, 4'hF, 1'b1, 1'b1, 1'b1);
        chk("drain", sb.size() == 0, 64'(sb.size()), 64'h0);
        @(negedge clk);
        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
